seq_det_1011_fsm: RTL



---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_1011_fsm_sat_counter.sv | 34 +++
 rtl/seq_det_1011_fsm.sv | 69 ++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 serial sequence detector: state encodings,
// state width and the reference pattern.
package seq_det_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_1011 = 3'd4
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_det_1011_fsm_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/seq_det_1011_fsm.sv
// Moore recogniser for serial pattern 1011 with registered detect pulse and
// saturating detection count. Define SEQ_DET_1011_MEALY_EN to add det_early.
module seq_det_1011_fsm
  import seq_det_pkg::*;
#(
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cnt_clear,
  output logic               detect,
  output logic [CNT_W-1:0]   det_count,
  output logic [STATE_W-1:0] state
`ifdef SEQ_DET_1011_MEALY_EN
  ,
  output logic               det_early
`endif
);

  state_e state_q;
  state_e state_d;
  logic   detect_q;
  logic   detect_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (din_valid) state_d = din ? S_1    : S_IDLE;
      S_1:     if (din_valid) state_d = din ? S_1    : S_10;
      S_10:    if (din_valid) state_d = din ? S_101  : S_IDLE;
      S_101:   if (din_valid) state_d = din ? S_1011 : S_10;
      S_1011:  if (din_valid) state_d = din ? S_1 : ((OVERLAP != 0) ? S_10 : S_IDLE);
      // Illegal encodings recover unconditionally, even without a valid bit.
      default: state_d = S_IDLE;
    endcase
    detect_d = din_valid && (state_d == S_1011);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      detect_q <= detect_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_det_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (detect_d),
    .clr   (cnt_clear),
    .count (det_count)
  );

  assign detect = detect_q;
  assign state  = state_q;

`ifdef SEQ_DET_1011_MEALY_EN
  assign det_early = din_valid && din && (state_q == S_101);
`endif

endmodule
